// File: rtl/spi_word_serializer.sv
// spi_word_serializer
// Buffers W-bit words in a small circular FIFO and presents them one byte
// at a time to an SPI slave shifter, in MSB-first or LSB-first order.
//
// Handshake: a word is accepted when data_ready=1 and full=0. A write seen
// while full=1 is dropped and sets the sticky overflow flag. On the output
// side, send=1 means byte_data/byte_index hold a byte that has not been
// consumed yet. The shifter consumes it with a single-cycle next_byte pulse,
// and the next byte is presented on the following cycle. next_byte is
// ignored while send=0.
module spi_word_serializer #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  localparam int W    = 8 * WORD_BYTES,
  localparam int IDXW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [W-1:0]    data,
  input  logic            data_ready,
  output logic            full,
  output logic [LW-1:0]   level,
  output logic            overflow,
  input  logic            clear_overflow,
  input  logic            next_byte,
  output logic            send,
  output logic [7:0]      byte_data,
  output logic [IDXW-1:0] byte_index,
  output logic            frame_start,
  output logic            fsm_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count, count_nxt;
  logic            full_q;
  logic            overflow_q;

  logic            push;
  logic            drop;
  logic            pop;
  logic            advance;
  logic            last_byte;

  logic [W-1:0]    word_q;
  logic [IDXW-1:0] idx_q;
  logic [7:0]      byte_q;

  // Byte at send position pos of word w, honouring the configured order.
  function automatic logic [7:0] pick_byte(input logic [W-1:0] w,
                                           input logic [IDXW-1:0] pos);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (IDXW'(k) == pos) begin
        if (MSB_FIRST)
          r = w[8*(WORD_BYTES-1-k) +: 8];
        else
          r = w[8*k +: 8];
      end
    end
    return r;
  endfunction

  // Write side: the registered full flag gates acceptance, so a write while
  // full is dropped even if the serializer pops in the same cycle.
  assign push = data_ready && !full_q;
  assign drop = data_ready && full_q;

  assign last_byte = (idx_q == IDXW'(WORD_BYTES - 1));

  // State register of the serializer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and pop/advance decisions. Pops look only at the current
  // occupancy, so a word written this cycle is never popped this cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (next_byte) begin
          if (!last_byte) begin
            advance = 1'b1;
          end else if (count != '0) begin
            pop = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + LW'(1);
      2'b01:   count_nxt = count - LW'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers, occupancy and the registered full flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == LW'(DEPTH));
    end
  end

  // FIFO storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= data;
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      overflow_q <= 1'b0;
    else if (drop)
      overflow_q <= 1'b1;
    else if (clear_overflow)
      overflow_q <= 1'b0;
  end

  // Shift register, byte position and registered output byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
      byte_q <= '0;
    end else if (pop) begin
      word_q <= mem[rd_ptr];
      idx_q  <= '0;
      byte_q <= pick_byte(mem[rd_ptr], '0);
    end else if (advance) begin
      idx_q  <= idx_q + IDXW'(1);
      byte_q <= pick_byte(word_q, idx_q + IDXW'(1));
    end
  end

  assign full        = full_q;
  assign level       = count;
  assign overflow    = overflow_q;
  assign send        = (state == S_SHIFT);
  assign byte_data   = byte_q;
  assign byte_index  = idx_q;
  assign frame_start = (state == S_SHIFT) && (idx_q == '0);
  assign fsm_state   = state;

endmodule

// File: tb/tb_spi_word_serializer.sv
// Bench for spi_word_serializer: default instance against a queue-based
// reference model, plus a WORD_BYTES=2/DEPTH=2/LSB-first instance with
// directed expectations.
module tb_spi_word_serializer;

  localparam int WB = 4;
  localparam int DP = 4;
  localparam bit MF = 1'b1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // main instance (defaults)
  logic [31:0] data = '0;
  logic        data_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        next_byte = 1'b0;
  logic        full, overflow, send, frame_start, fsm_state;
  logic [2:0]  level;
  logic [7:0]  byte_data;
  logic [1:0]  byte_index;

  // second instance (WORD_BYTES=2, DEPTH=2, LSB first)
  logic [15:0] data2 = '0;
  logic        data_ready2 = 1'b0;
  logic        next_byte2 = 1'b0;
  logic        full2, overflow2, send2, frame_start2, fsm_state2;
  logic [1:0]  level2;
  logic [7:0]  byte2;
  logic [0:0]  byte_index2;

  spi_word_serializer u_dut (
    .clock(clock), .reset(reset), .data(data), .data_ready(data_ready),
    .full(full), .level(level), .overflow(overflow),
    .clear_overflow(clear_overflow), .next_byte(next_byte), .send(send),
    .byte_data(byte_data), .byte_index(byte_index),
    .frame_start(frame_start), .fsm_state(fsm_state)
  );

  spi_word_serializer #(.WORD_BYTES(2), .DEPTH(2), .MSB_FIRST(1'b0)) u_dut2 (
    .clock(clock), .reset(reset), .data(data2), .data_ready(data_ready2),
    .full(full2), .level(level2), .overflow(overflow2),
    .clear_overflow(1'b0), .next_byte(next_byte2), .send(send2),
    .byte_data(byte2), .byte_index(byte_index2),
    .frame_start(frame_start2), .fsm_state(fsm_state2)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];   // words waiting in the FIFO
  logic [7:0]  m_bytes[$]; // remaining bytes of the word being sent, head = current
  int          m_idx;
  bit          m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_bytes.delete();
    m_idx = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_load();
    logic [31:0] w;
    int sh;
    w = exp_q.pop_front();
    m_bytes.delete();
    for (int i = 0; i < WB; i++) begin
      sh = MF ? 8 * (WB - 1 - i) : 8 * i;
      m_bytes.push_back(8'((w >> sh) & 32'hff));
    end
    m_idx = 0;
  endtask

  // One clock edge of behaviour, from occupancy seen before the edge.
  task automatic model_step(input bit wr, input logic [31:0] d,
                            input bit nb, input bit clr);
    bit was_full;
    was_full = (exp_q.size() == DP);
    if (m_bytes.size() == 0) begin
      if (exp_q.size() > 0) model_load();
    end else if (nb) begin
      void'(m_bytes.pop_front());
      m_idx++;
      if (m_bytes.size() == 0 && exp_q.size() > 0) model_load();
    end
    if (wr && !was_full) exp_q.push_back(d);
    if (wr && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    bit busy;
    busy = (m_bytes.size() > 0);
    check_val("send", send, busy);
    check_val("level", level, exp_q.size());
    check_val("full", full, exp_q.size() == DP);
    check_val("overflow", overflow, m_ovf);
    check_val("frame_start", frame_start, busy && (m_idx == 0));
    if (busy) begin
      check_val("byte", byte_data, m_bytes[0]);
      check_val("byte_index", byte_index, m_idx);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs sampled likewise.
  task automatic cycle(input bit wr, input logic [31:0] d, input bit nb,
                       input bit clr);
    data_ready     = wr;
    data           = d;
    next_byte      = nb;
    clear_overflow = clr;
    @(posedge clock);
    model_step(wr, d, nb, clr);
    #1;
    check_outputs();
    data_ready     = 1'b0;
    next_byte      = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic cycle2(input bit wr, input logic [15:0] d, input bit nb);
    data_ready2 = wr;
    data2       = d;
    next_byte2  = nb;
    @(posedge clock);
    #1;
    data_ready2 = 1'b0;
    next_byte2  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_send"}, send, 0);
    check_val({tag, "_byte"}, byte_data, 0);
    check_val({tag, "_idx"}, byte_index, 0);
    check_val({tag, "_fs"}, frame_start, 0);
    check_val({tag, "_full"}, full, 0);
    check_val({tag, "_level"}, level, 0);
    check_val({tag, "_ovf"}, overflow, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("rst");
    reset = 1'b0;

    // LSB-first, two-byte words, write racing the last-byte pulse
    cycle2(1'b1, 16'hA1B2, 1'b0);
    check_val("d2_level1", level2, 1);
    check_val("d2_send0", send2, 0);
    cycle2(1'b0, 16'h0, 1'b0);
    check_val("d2_b0", byte2, 8'hB2);
    check_val("d2_fs0", frame_start2, 1);
    cycle2(1'b0, 16'h0, 1'b1);
    check_val("d2_b1", byte2, 8'hA1);
    check_val("d2_idx1", byte_index2, 1);
    cycle2(1'b1, 16'h5566, 1'b1);
    check_val("d2_gap_send", send2, 0);
    check_val("d2_gap_level", level2, 1);
    cycle2(1'b0, 16'h0, 1'b0);
    check_val("d2_new_send", send2, 1);
    check_val("d2_new_byte", byte2, 8'h66);
    check_val("d2_new_fs", frame_start2, 1);
    cycle2(1'b0, 16'h0, 1'b1);
    check_val("d2_new_b1", byte2, 8'h55);
    cycle2(1'b0, 16'h0, 1'b1);
    check_val("d2_end_send", send2, 0);

    // single word, MSB first
    cycle(1'b1, 32'hA1B2C3D4, 1'b0, 1'b0);
    check_val("w1_send_early", send, 0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("w1_first", byte_data, 8'hA1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("w1_send_end", send, 0);

    // fill past capacity, overflow and its clear
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0);
    check_val("fill_full", full, 1);
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check_val("ovf_set", overflow, 1);
    check_val("ovf_level", level, 4);
    cycle(1'b1, 32'hBADC0FFE, 1'b0, 1'b1);
    check_val("ovf_drop_beats_clear", overflow, 1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("ovf_clear", overflow, 0);

    // drain back to back: 20 bytes with next_byte held high
    for (int i = 0; i < 21; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset mid-word with two words queued
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async");
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("post_rst_idx", byte_index, 0);
    check_val("post_rst_byte", byte_data, 8'h0B);

    // random traffic, balanced then write-heavy
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 99) < 50, $urandom,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 99) < 80, $urandom,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
